regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port between NUM_REQ writeback sources, e.g. ALU, load unit and CSR/debug.
- Each source gets a one-entry holding buffer with valid/ready handshake.
- The arbiter selects one buffered write per cycle and drives it into registered write-port outputs (rf_we/rf_waddr/rf_wdata).
- pending_mask exposes outstanding destinations so the hazard unit can stall readers.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_wb_arbiter_core.sv | 64 ++++++
 rtl/regfile_wb_arbiter.sv | 135 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Widths here fix the holding-buffer entry layout used by regfile_wb_arbiter.
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 2**ADDR_W;

    // One buffered writeback: destination register and value.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // Register address to one-hot register mask.
    function automatic logic [NUM_REGS-1:0] onehot_decode(input logic [ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] v;
        v       = '0;
        v[addr] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_core.sv
// Writeback grant selection: at most one one-hot grant per cycle.
// WB_ARB_RR_EN defined: round-robin, search starts one past the last winner.
// WB_ARB_RR_EN undefined: fixed priority, lowest index wins, no pointer state.
module wb_arb_core
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
`ifdef WB_ARB_RR_EN
    input  logic               clk,
    input  logic               rst_n,
`endif
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_id,
    output logic               o_any
);

`ifdef WB_ARB_RR_EN
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_idx;

    // Rotating search from r_ptr+1; first requesting index wins.
    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        o_any      = 1'b0;
        w_idx      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDX_W'((32'(r_ptr) + k) % NUM_REQ);
            if (!o_any && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_grant_id     = w_idx;
                o_any          = 1'b1;
            end
        end
    end

    // Pointer remembers the most recent winner; idle cycles leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= IDX_W'(NUM_REQ - 1);
        end else if (o_any) begin
            r_ptr <= o_grant_id;
        end
    end
`else
    // Fixed priority: lowest requesting index wins.
    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        o_any      = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!o_any && i_req[i]) begin
                o_grant[i] = 1'b1;
                o_grant_id = IDX_W'(i);
                o_any      = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: NUM_REQ one-entry holding buffers feed a
// registered write port; pending_mask reports every outstanding destination.
// Arbitration policy selected by macro WB_ARB_RR_EN (round-robin when defined,
// fixed priority otherwise). Buffer entry widths follow regfile_pkg.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = regfile_pkg::ADDR_W,
    parameter int DATA_W  = regfile_pkg::DATA_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        rf_we,
    output logic [ADDR_W-1:0]           rf_waddr,
    output logic [DATA_W-1:0]           rf_wdata,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic [2**ADDR_W-1:0]        pending_mask
);
    import regfile_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    wb_req_t              r_buf [NUM_REQ];
    logic [NUM_REQ-1:0]   r_buf_v;
    logic                 r_rf_we;
    logic [ADDR_W-1:0]    r_rf_waddr;
    logic [DATA_W-1:0]    r_rf_wdata;
    logic [IDX_W-1:0]     r_grant_id;

    logic [NUM_REQ-1:0]   w_arb_req;
    logic [NUM_REQ-1:0]   w_grant;
    logic [IDX_W-1:0]     w_grant_id;
    logic                 w_any;
    logic [NUM_REQ-1:0]   w_ready;
    logic [NUM_REQ-1:0]   w_accept;
    wb_req_t              w_win;
    logic [2**ADDR_W-1:0] w_pending;

    // Masking the arbiter input during flush suppresses that cycle's grant
    // and keeps the round-robin pointer from advancing.
    assign w_arb_req = flush ? '0 : r_buf_v;

    wb_arb_core #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
`ifdef WB_ARB_RR_EN
        .clk        (clk),
        .rst_n      (rst_n),
`endif
        .i_req      (w_arb_req),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id),
        .o_any      (w_any)
    );

    assign w_ready   = flush ? '0 : (~r_buf_v | w_grant);
    assign w_accept  = req_valid & w_ready;
    assign req_ready = w_ready;

    // Holding buffers: flush clears, accept (re)fills, grant drains; x0 never stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_v <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (flush) begin
                    r_buf_v[i] <= 1'b0;
                end else if (w_accept[i]) begin
                    r_buf_v[i]    <= (req_addr[i*ADDR_W +: ADDR_W] != '0);
                    r_buf[i].addr <= req_addr[i*ADDR_W +: ADDR_W];
                    r_buf[i].data <= req_data[i*DATA_W +: DATA_W];
                end else if (w_grant[i]) begin
                    r_buf_v[i] <= 1'b0;
                end
            end
        end
    end

    // Winner's buffered entry, selected by the one-hot grant.
    always_comb begin
        w_win = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_win = r_buf[i];
            end
        end
    end

    // Registered write port: enable follows the grant, address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_grant_id <= '0;
        end else begin
            r_rf_we <= w_any;
            if (w_any) begin
                r_rf_waddr <= w_win.addr;
                r_rf_wdata <= w_win.data;
                r_grant_id <= w_grant_id;
            end
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;
    assign grant_id = r_grant_id;

    // Outstanding destinations: valid buffers plus the live output stage; x0 never reported.
    always_comb begin
        w_pending = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_buf_v[i]) begin
                w_pending = w_pending | onehot_decode(r_buf[i].addr);
            end
        end
        if (r_rf_we) begin
            w_pending = w_pending | onehot_decode(r_rf_waddr);
        end
        w_pending[0] = 1'b0;
    end

    assign pending_mask = w_pending;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter; follows WB_ARB_RR_EN the same way as the design.
module tb_regfile_wb_arbiter;

    localparam int NR   = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int IW   = 2;
    localparam int NREG = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [DW-1:0]     rf_wdata;
    logic [IW-1:0]     grant_id;
    logic [NREG-1:0]   pending_mask;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .grant_id     (grant_id),
        .pending_mask (pending_mask)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each requester holds at most one write; the port shows the last granted write.
    bit          m_v  [NR];
    logic [AW-1:0] m_a [NR];
    logic [DW-1:0] m_d [NR];
    bit          m_we;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;
    int          m_gid;
    int          m_ptr;
    bit          model_live = 1'b0;

    function automatic int pick_winner();
        if (flush) return -1;
`ifdef WB_ARB_RR_EN
        for (int k = 1; k <= NR; k++) begin
            int j;
            j = (m_ptr + k) % NR;
            if (m_v[j]) return j;
        end
`else
        for (int j = 0; j < NR; j++) begin
            if (m_v[j]) return j;
        end
`endif
        return -1;
    endfunction

    // Compare DUT against the model each cycle, then advance the model one edge.
    always @(negedge clk) begin
        int            w;
        logic [NR-1:0] e_rdy;
        logic [NREG-1:0] e_pm;
        logic [AW-1:0] a;
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) begin
                m_v[i] = 1'b0; m_a[i] = '0; m_d[i] = '0;
            end
            m_we = 1'b0; m_wa = '0; m_wd = '0; m_gid = 0; m_ptr = NR - 1;
            model_live = 1'b1;
        end
        if (model_live) begin
            w = pick_winner();
            for (int i = 0; i < NR; i++) e_rdy[i] = !flush && (!m_v[i] || w == i);
            e_pm = '0;
            for (int i = 0; i < NR; i++) if (m_v[i]) e_pm[m_a[i]] = 1'b1;
            if (m_we) e_pm[m_wa] = 1'b1;
            e_pm[0] = 1'b0;
            check("m_ready",    req_ready,    e_rdy);
            check("m_rf_we",    rf_we,        m_we);
            check("m_rf_waddr", rf_waddr,     m_wa);
            check("m_rf_wdata", rf_wdata,     m_wd);
            check("m_grant_id", grant_id,     m_gid);
            check("m_pending",  pending_mask, e_pm);
            if (rst_n) begin
                if (w >= 0) begin
                    m_we = 1'b1; m_wa = m_a[w]; m_wd = m_d[w]; m_gid = w; m_ptr = w;
                end else begin
                    m_we = 1'b0;
                end
                for (int i = 0; i < NR; i++) begin
                    a = req_addr[i*AW +: AW];
                    if (flush) m_v[i] = 1'b0;
                    else if (req_valid[i] && e_rdy[i]) begin
                        m_v[i] = (a != 0); m_a[i] = a; m_d[i] = req_data[i*DW +: DW];
                    end else if (w == i) m_v[i] = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_idle();
        req_valid = '0; req_addr = '0; req_data = '0; flush = 1'b0;
    endtask

    task automatic next();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = 1'b1;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic random_cycles(input int n, input int flush_pct);
        for (int c = 0; c < n; c++) begin
            next();
            drive_idle();
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(99) < 65)
                    set_req(i, ($urandom_range(7) == 0) ? 5'd0 : AW'($urandom_range(31)), $urandom);
            end
            flush = ($urandom_range(99) < flush_pct);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_we",    rf_we,        0);
        check("reset_pm",    pending_mask, 0);
        check("reset_rdy",   req_ready,    3'b111);
        check("reset_waddr", rf_waddr,     0);

        // Traffic, then reset with all buffers full.
        random_cycles(40, 0);
        next(); drive_idle();
        set_req(0, 5'd20, 32'hA0); set_req(1, 5'd21, 32'hA1); set_req(2, 5'd22, 32'hA2);
        next(); next();
        #1 rst_n = 1'b0; drive_idle();
        @(negedge clk);
        check("midrst_we",  rf_we,        0);
        check("midrst_pm",  pending_mask, 0);
        check("midrst_rdy", req_ready,    3'b111);

        // First write after reset: accepted at edge N, visible after edge N+1.
        next(); rst_n = 1'b1;
        set_req(0, 5'd5, 32'hDEADBEEF);
        @(posedge clk); #1 drive_idle();
        @(negedge clk);
        check("x5_we_early", rf_we, 0);
        check("x5_pm5",      pending_mask[5], 1);
        @(negedge clk);
        check("x5_we",    rf_we,    1);
        check("x5_waddr", rf_waddr, 5);
        check("x5_wdata", rf_wdata, 32'hDEADBEEF);
        repeat (3) next();

        // Single requester streaming x1..x8.
        for (int k = 1; k <= 8; k++) begin
            next(); drive_idle(); set_req(0, AW'(k), 32'h100 + k);
            @(negedge clk);
            check("stream_rdy", req_ready[0], 1);
            if (k >= 3) begin
                check("stream_we",    rf_we,    1);
                check("stream_addr",  rf_waddr, k - 2);
                check("stream_wdata", rf_wdata, 32'h100 + k - 2);
            end
        end
        for (int k = 7; k <= 8; k++) begin
            next(); drive_idle();
            @(negedge clk);
            check("stream_we",   rf_we,    1);
            check("stream_addr", rf_waddr, k);
        end
        next();
        @(negedge clk);
        check("stream_end", rf_we, 0);

        // Contention: x10/x11/x12 held for 6 cycles; last winner so far is requester 0.
        for (int c = 0; c < 6; c++) begin
            next(); drive_idle();
            set_req(0, 5'd10, 32'h10); set_req(1, 5'd11, 32'h11); set_req(2, 5'd12, 32'h12);
            @(negedge clk);
            if (c >= 2) begin
                check("cont_we", rf_we, 1);
`ifdef WB_ARB_RR_EN
                check("cont_rr_gid", grant_id, (c - 1) % 3);
`else
                check("cont_fixed_gid",  grant_id,       0);
                check("cont_fixed_rdy",  req_ready[2:1], 0);
                check("cont_fixed_addr", rf_waddr,       10);
`endif
            end
        end
        next(); drive_idle();
        repeat (5) next();

        // x0 write completes the handshake but never reaches the port.
        set_req(1, 5'd0, 32'h1234);
        @(negedge clk);
        check("x0_rdy", req_ready[1], 1);
        next(); drive_idle();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("x0_we",  rf_we,           0);
            check("x0_pm0", pending_mask[0], 0);
            next();
        end

        // Flush with x3/x4 buffered and x7 in the output stage.
        set_req(2, 5'd7, 32'h77);
        next(); drive_idle(); set_req(0, 5'd3, 32'h33); set_req(1, 5'd4, 32'h44);
        next(); drive_idle(); flush = 1'b1;
        @(negedge clk);
        check("flush_rdy",   req_ready,    0);
        check("flush_we",    rf_we,        1);
        check("flush_waddr", rf_waddr,     7);
        check("flush_pm",    pending_mask, 32'h0000_0098);
        next(); drive_idle();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("postflush_we", rf_we,        0);
            check("postflush_pm", pending_mask, 0);
            next();
        end

        // pending_mask lifetime for x9 from requester 2.
        set_req(2, 5'd9, 32'h99);
        next(); drive_idle();
        @(negedge clk);
        check("pm9_buf",    pending_mask[9], 1);
        check("pm9_buf_we", rf_we,           0);
        next();
        @(negedge clk);
        check("pm9_out_we",   rf_we,           1);
        check("pm9_out_addr", rf_waddr,        9);
        check("pm9_out",      pending_mask[9], 1);
        next();
        @(negedge clk);
        check("pm9_done_we", rf_we,           0);
        check("pm9_done",    pending_mask[9], 0);

        // Randomised traffic with occasional flush.
        random_cycles(400, 10);
        next(); drive_idle();
        repeat (6) next();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
